// File: rtl/nv_nvdla_csc_accu_credit_if.sv
// Signal bundle between the convolution sequencer and its CACC credit tracker.
// The master side is the requester/credit source; the slave side is the tracker.
interface nv_nvdla_csc_accu_credit_if #(
  parameter int CNT_W = 7
);
  logic             sc_req_vld;
  logic             sc_req_rdy;
  logic [CNT_W-1:0] sc_req_size;
  logic             accu2sc_credit_vld;
  logic [2:0]       accu2sc_credit_size;
  logic             sc_drain_req;
  logic             sc_drain_done;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_idle;
  logic             err_clr;
  logic             credit_ovf_err;
  logic             credit_size_err;

  modport master (
    output sc_req_vld, sc_req_size, accu2sc_credit_vld, accu2sc_credit_size,
           sc_drain_req, err_clr,
    input  sc_req_rdy, sc_drain_done, credit_cnt, credit_idle,
           credit_ovf_err, credit_size_err
  );

  modport slave (
    input  sc_req_vld, sc_req_size, accu2sc_credit_vld, accu2sc_credit_size,
           sc_drain_req, err_clr,
    output sc_req_rdy, sc_drain_done, credit_cnt, credit_idle,
           credit_ovf_err, credit_size_err
  );
endinterface

// File: rtl/nv_nvdla_csc_accu_credit.sv
// CACC assembly-buffer credit tracker: grants stripe requests against free
// entries, replenishes from retimed credit returns, and supports a drain wait.
module nv_nvdla_csc_accu_credit #(
  parameter int CREDIT_MAX = 64,
  parameter int CNT_W      = 7
) (
  input logic                    nvdla_core_clk,
  input logic                    nvdla_core_rst,
  nv_nvdla_csc_accu_credit_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(CREDIT_MAX);
  localparam logic [CNT_W:0]   MAX_WIDE = (CNT_W+1)'(CREDIT_MAX);

  state_e           state_q, state_d;
  logic             ret_vld_q;
  logic [2:0]       ret_size_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_err_q, ovf_err_d;
  logic             size_err_q, size_err_d;

  logic             req_fits;
  logic             grant;
  logic             idle;
  logic [CNT_W:0]   sum;
  logic             ovf_evt;
  logic             size_evt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idle     = (cnt_q == MAX_CNT) && !ret_vld_q;
    req_fits = ({1'b0, bus.sc_req_size} <= MAX_WIDE);
    grant    = bus.sc_req_vld && (state_q == RUN) && (cnt_q >= bus.sc_req_size) && req_fits;

    // One extra bit so a return on top of a near-full count is seen as overflow.
    sum      = {1'b0, cnt_q}
             - (grant     ? {1'b0, bus.sc_req_size}  : '0)
             + (ret_vld_q ? (CNT_W+1)'(ret_size_q)   : '0);
    ovf_evt  = (sum > MAX_WIDE);
    cnt_d    = ovf_evt ? MAX_CNT : sum[CNT_W-1:0];

    size_evt   = (ret_vld_q && (ret_size_q == 3'd0)) || (bus.sc_req_vld && !req_fits);
    // A new error event outranks a simultaneous clear.
    ovf_err_d  = ovf_evt  || (ovf_err_q  && !bus.err_clr);
    size_err_d = size_evt || (size_err_q && !bus.err_clr);

    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.sc_drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (idle) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= RUN;
      ret_vld_q  <= 1'b0;
      ret_size_q <= 3'd0;
      cnt_q      <= MAX_CNT;
      done_q     <= 1'b0;
      ovf_err_q  <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_vld_q  <= bus.accu2sc_credit_vld;
      ret_size_q <= bus.accu2sc_credit_size;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ovf_err_q  <= ovf_err_d;
      size_err_q <= size_err_d;
    end
  end

  assign bus.sc_req_rdy      = grant;
  assign bus.sc_drain_done   = done_q;
  assign bus.credit_cnt      = cnt_q;
  assign bus.credit_idle     = idle;
  assign bus.credit_ovf_err  = ovf_err_q;
  assign bus.credit_size_err = size_err_q;

endmodule

// File: tb/tb_nv_nvdla_csc_accu_credit.sv
// Directed bench for the CACC credit tracker; grants and drain completions are
// checked by a scoreboard monitor, other state by direct comparisons.
module tb_nv_nvdla_csc_accu_credit;

  localparam int CNT_W = 7;

  typedef struct {
    int size;
    int cnt;
  } grant_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  grant_t gq[$];
  int     dq[$];

  nv_nvdla_csc_accu_credit_if #(.CNT_W(CNT_W)) bus ();

  nv_nvdla_csc_accu_credit #(.CREDIT_MAX(64), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int size, input int cnt);
    grant_t g;
    g.size = size;
    g.cnt  = cnt;
    gq.push_back(g);
  endtask

  // Scoreboard monitor: pops on every grant and every drain-done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sc_req_vld && bus.sc_req_rdy) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", {25'd0, bus.sc_req_size}, 32'hFFFF_FFFF);
        end else begin
          grant_t g;
          g = gq.pop_front();
          check("grant_size", {25'd0, bus.sc_req_size}, g.size);
          check("grant_cnt",  {25'd0, bus.credit_cnt},  g.cnt);
        end
      end
      if (bus.sc_drain_done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", {25'd0, bus.credit_cnt}, 32'hFFFF_FFFF);
        end else begin
          int e;
          e = dq.pop_front();
          check("done_cnt", {25'd0, bus.credit_cnt}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ret_tab[4] = '{7, 7, 3, 0};
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.sc_req_vld          = 1'b0;
    bus.sc_req_size         = '0;
    bus.accu2sc_credit_vld  = 1'b0;
    bus.accu2sc_credit_size = 3'd0;
    bus.sc_drain_req        = 1'b0;
    bus.err_clr             = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cnt",      bus.credit_cnt, 64);
    check("rst_idle",     bus.credit_idle, 1);
    check("rst_ovf",      bus.credit_ovf_err, 0);
    check("rst_size_err", bus.credit_size_err, 0);
    check("rst_done",     bus.sc_drain_done, 0);
    check("rst_rdy",      bus.sc_req_rdy, 0);
    step();

    // Full consume, then hold-off
    push_grant(64, 64);
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd64;
    @(negedge clk); check("full_rdy", bus.sc_req_rdy, 1);
    step(); bus.sc_req_size = 7'd1;
    @(negedge clk);
    check("full_cnt", bus.credit_cnt, 0);
    check("hold_rdy", bus.sc_req_rdy, 0);
    step(); bus.sc_req_vld = 1'b0;

    // Return latency: return at T, usable at T+2
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd5;
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd5;
    push_grant(5, 5);
    @(negedge clk); check("lat_t0_rdy", bus.sc_req_rdy, 0);
    step(); bus.accu2sc_credit_vld = 1'b0;
    @(negedge clk);
    check("lat_t1_cnt", bus.credit_cnt, 0);
    check("lat_t1_rdy", bus.sc_req_rdy, 0);
    step();
    @(negedge clk);
    check("lat_t2_cnt", bus.credit_cnt, 5);
    check("lat_t2_rdy", bus.sc_req_rdy, 1);
    step(); bus.sc_req_vld = 1'b0;
    @(negedge clk); check("lat_after_cnt", bus.credit_cnt, 0);

    // Build up to 10, then grant 8 with a flopped return of 3 in the same cycle
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd7;
    step(); bus.accu2sc_credit_size = 3'd3;
    step(); bus.accu2sc_credit_vld = 1'b0;
    step();
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd3;
    @(negedge clk); check("sim_pre_cnt", bus.credit_cnt, 10);
    step(); bus.accu2sc_credit_vld = 1'b0;
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd8;
    push_grant(8, 10);
    @(negedge clk); check("sim_rdy", bus.sc_req_rdy, 1);
    step(); bus.sc_req_vld = 1'b0;
    @(negedge clk); check("sim_cnt", bus.credit_cnt, 5);

    // Overflow: 62 + 7 saturates at 64
    step();
    rst = 1'b1; #2; rst = 1'b0;
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd2;
    push_grant(2, 64);
    step(); bus.sc_req_vld = 1'b0;
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd7;
    @(negedge clk); check("ovf_pre_cnt", bus.credit_cnt, 62);
    step(); bus.accu2sc_credit_vld = 1'b0;
    @(negedge clk); check("ovf_mid_err", bus.credit_ovf_err, 0);
    step();
    @(negedge clk);
    check("ovf_cnt", bus.credit_cnt, 64);
    check("ovf_err", bus.credit_ovf_err, 1);
    step(); bus.err_clr = 1'b1;
    step(); bus.err_clr = 1'b0;
    @(negedge clk); check("ovf_clr", bus.credit_ovf_err, 0);

    // Drain from 40 with returns 7,7,7,3
    step();
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd24;
    push_grant(24, 64);
    step(); bus.sc_req_vld = 1'b0; bus.sc_drain_req = 1'b1;
    @(negedge clk); check("drn_start_cnt", bus.credit_cnt, 40);
    step(); bus.sc_drain_req = 1'b0;
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd1;
    push_grant(1, 64);
    dq.push_back(64);
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd7;
    @(negedge clk); check("drn_rdy_c0", bus.sc_req_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.accu2sc_credit_vld  = (ret_tab[i] != 0);
      bus.accu2sc_credit_size = 3'(ret_tab[i]);
      @(negedge clk); check("drn_rdy_loop", bus.sc_req_rdy, 0);
    end
    step();
    @(negedge clk);
    check("drn_c5_cnt",  bus.credit_cnt, 64);
    check("drn_c5_rdy",  bus.sc_req_rdy, 0);
    check("drn_c5_done", bus.sc_drain_done, 0);
    step();
    @(negedge clk);
    check("drn_c6_done", bus.sc_drain_done, 1);
    check("drn_c6_rdy",  bus.sc_req_rdy, 1);
    step(); bus.sc_req_vld = 1'b0;
    @(negedge clk);
    check("drn_c7_done", bus.sc_drain_done, 0);
    check("drn_c7_cnt",  bus.credit_cnt, 63);

    // Illegal sizes: return of 0, request of 65
    step();
    bus.accu2sc_credit_vld = 1'b1; bus.accu2sc_credit_size = 3'd0;
    step(); bus.accu2sc_credit_vld = 1'b0;
    step();
    @(negedge clk);
    check("zero_ret_cnt", bus.credit_cnt, 63);
    check("zero_ret_err", bus.credit_size_err, 1);
    step(); bus.err_clr = 1'b1;
    step(); bus.err_clr = 1'b0;
    @(negedge clk); check("zero_ret_clr", bus.credit_size_err, 0);
    step();
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd65;
    @(negedge clk); check("big_rdy0", bus.sc_req_rdy, 0);
    step(); bus.err_clr = 1'b1;
    @(negedge clk);
    check("big_rdy1", bus.sc_req_rdy, 0);
    check("big_err",  bus.credit_size_err, 1);
    step(); bus.err_clr = 1'b0;
    @(negedge clk);
    check("big_err_wins", bus.credit_size_err, 1);
    check("big_rdy2",     bus.sc_req_rdy, 0);
    step(); bus.sc_req_vld = 1'b0; bus.err_clr = 1'b1;
    step(); bus.err_clr = 1'b0;
    @(negedge clk);
    check("big_clr", bus.credit_size_err, 0);
    check("big_cnt", bus.credit_cnt, 63);

    // Asynchronous reset while draining at 12
    step();
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd51;
    push_grant(51, 63);
    step(); bus.sc_req_vld = 1'b0; bus.sc_drain_req = 1'b1;
    @(negedge clk); check("ar_pre_cnt", bus.credit_cnt, 12);
    step(); bus.sc_drain_req = 1'b0;
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd65;
    @(negedge clk); check("ar_drain_rdy", bus.sc_req_rdy, 0);
    step(); bus.sc_req_vld = 1'b0;
    @(negedge clk);
    check("ar_pre_err", bus.credit_size_err, 1);
    check("ar_pre_cnt2", bus.credit_cnt, 12);
    #2; rst = 1'b1;
    #1;
    check("ar_cnt",      bus.credit_cnt, 64);
    check("ar_done",     bus.sc_drain_done, 0);
    check("ar_ovf",      bus.credit_ovf_err, 0);
    check("ar_size_err", bus.credit_size_err, 0);
    check("ar_idle",     bus.credit_idle, 1);
    bus.sc_req_vld = 1'b1; bus.sc_req_size = 7'd1;
    #1; check("ar_run_rdy", bus.sc_req_rdy, 1);
    bus.sc_req_vld = 1'b0;
    #2; rst = 1'b0;
    step();
    @(negedge clk); check("ar_post_cnt", bus.credit_cnt, 64);

    check("grant_queue_empty", gq.size(), 0);
    check("drain_queue_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_csc_accu_credit.md
# nv_nvdla_csc_accu_credit

Credit tracker on the convolution-sequencer side of the CACC credit return path. Holds the count of free CACC assembly-buffer entries, grants stripe-issue requests only when enough credit exists, and replenishes credit from `accu2sc_credit_vld`/`accu2sc_credit_size` returned by the accumulator partition. Also provides a drain handshake so that layer-end logic can wait until every outstanding entry has been returned.

## Interface
- `CREDIT_MAX`, 64: total assembly-buffer entries, and the credit value after reset.
- `CNT_W`, 7: counter width. Must satisfy 2^CNT_W > CREDIT_MAX.
- `nvdla_core_clk` in 1: sole clock.
- `nvdla_core_rst` in 1: asynchronous, active-high reset.
- `sc_req_vld` in 1: stripe-issue request valid.
- `sc_req_rdy` out 1: request granted this cycle.
- `sc_req_size` in CNT_W: entries the stripe will consume.
- `accu2sc_credit_vld` in 1: credit return valid, one cycle per pulse.
- `accu2sc_credit_size` in 3: entries returned, 1..7; 0 is illegal.
- `sc_drain_req` in 1: pulse that starts a drain.
- `sc_drain_done` out 1: single-cycle pulse when the drain completes.
- `credit_cnt` out CNT_W: current free entries, registered.
- `credit_idle` out 1: `credit_cnt == CREDIT_MAX` and the return stage is empty.
- `err_clr` in 1: clears the sticky error flags.
- `credit_ovf_err` out 1: sticky; a return would exceed CREDIT_MAX.
- `credit_size_err` out 1: sticky; set by a return of size 0, or by a request with `sc_req_size > CREDIT_MAX`.

## Operation
- **Return stage.** The return inputs are flopped once, into `ret_vld_q` and `ret_size_q`, for partition retiming. Only the flopped values update the counter.
- **Grant rule.** `sc_req_rdy = sc_req_vld && state==RUN && credit_cnt >= sc_req_size`.
  - The comparison uses the registered `credit_cnt` only. A return arriving in the same cycle does not help the current request.
  - A request with `sc_req_size == 0` is granted whenever in RUN and leaves the count unchanged.
  - The handshake is a valid/ready transfer. The requester holds `sc_req_vld` and `sc_req_size` stable until `sc_req_rdy`.
- **Counter update.** `next = credit_cnt - (grant ? sc_req_size : 0) + (ret_vld_q ? ret_size_q : 0)`, computed CNT_W+1 bits wide.
  - If `next > CREDIT_MAX`: the counter loads CREDIT_MAX and `credit_ovf_err` sets.
  - Underflow cannot occur because of the grant rule.
- **Illegal sizes.**
  - A return of size 0 sets `credit_size_err` and adds nothing.
  - A request with `sc_req_size > CREDIT_MAX` is never granted. While it is presented, `credit_size_err` sets.
- **State machine.**
  - States: RUN (reset state) and DRAIN.
  - RUN -> DRAIN on `sc_drain_req`. Grants are blocked from the next cycle on. A grant in the same cycle as `sc_drain_req` is still honoured.
  - In DRAIN, `sc_drain_req` is ignored.
  - DRAIN -> RUN when `credit_idle`. `sc_drain_done` pulses in the cycle the state returns to RUN.
  - If DRAIN is entered while already idle, the transition back to RUN happens on the next edge.
- **Error clearing.** `err_clr` clears both sticky errors. If `err_clr` coincides with a new error event, the error wins.

## Timing
- Reset values:
  - `credit_cnt` = CREDIT_MAX
  - state = RUN
  - `ret_vld_q` = 0, `ret_size_q` = 0
  - `sc_drain_done` = 0
  - both error flags = 0
  - `sc_req_rdy` follows its combinational term from the reset state.
- `sc_req_rdy` is combinational from `sc_req_vld`, `sc_req_size` and registered state.
- Grant at edge N: `credit_cnt` reflects the deduction after edge N.
- Return visible at edge N: the flop captures it at N; `credit_cnt` includes it after edge N+1 (two-cycle latency).
- Back-to-back returns and back-to-back grants are each sustained at one per cycle.
- Reset asserted mid-operation restores all reset values immediately, regardless of clock. A return in flight is discarded; the upstream CACC is reset in the same domain.

## Test plan
- **Reset, then full consume.** Reset, then request size 64 -> `sc_req_rdy`=1 in the same cycle, `credit_cnt`=0 the next cycle. A subsequent request of size 1 is held off with `sc_req_rdy`=0.
- **Return latency.** `credit_cnt`=0. Return size 5 at cycle T -> `credit_cnt`=5 at T+2. A pending request of size 5 is granted at T+2, not earlier.
- **Simultaneous grant and return.** `credit_cnt`=10, grant 8 and `ret_vld_q` size 3 in the same cycle -> `credit_cnt`=5. With `credit_cnt`=62 and no grant, a return of 7 -> `credit_cnt`=64 and `credit_ovf_err`=1. Then `err_clr` -> 0.
- **Drain.** `credit_cnt`=40, `sc_drain_req` -> `sc_req_rdy` stays 0 for a pending request of size 1. Returns of 7, 7, 7, 3 -> `sc_drain_done` pulses once, one cycle after `credit_cnt` reaches 64. The request is granted afterwards.
- **Illegal sizes.** Return of size 0 -> count unchanged, `credit_size_err`=1. Request size 65 -> never granted, `credit_size_err`=1.
- **Asynchronous reset.** Assert `nvdla_core_rst` between clock edges while in DRAIN with `credit_cnt`=12 -> immediately state=RUN, `credit_cnt`=64, `sc_drain_done`=0, errors=0.
